snake_dir_queue: RTL and testbench
==================================

# snake_dir_queue

Turn-command stage directly downstream of the per-button debouncers in the snake game. It takes the four debounced direction buttons and converts each press into a direction request. Requests that would be no-ops or 180° reversals are rejected, and valid requests are buffered in a small FIFO. The game-logic step tick consumes one buffered turn at a time, so fast double-taps (e.g. up-then-left within one game step) are not lost.

## Interface
- DEPTH, 2: turn FIFO entries; power of two, ≥2. CW = $clog2(DEPTH)+1.
- clk  in  1  system clock (~25 MHz)
- reset  in  1  asynchronous, active-high; clears all state
- btn_up / btn_right / btn_down / btn_left  in  1 each  debounced button levels
- tick  in  1  one-cycle game-step pulse; consumes one queued turn
- clear  in  1  synchronous game restart
- dir  out  2  current heading: UP=0, RIGHT=1, DOWN=2, LEFT=3
- turned  out  1  registered pulse, high the cycle after dir changed via tick
- count  out  CW  queued turns, 0..DEPTH
- dropped  out  1  registered pulse: a press was rejected because the FIFO was full

## Operation
- Edge detect: per button, prev register (reset 0); press = btn & ~prev; prev <= btn every cycle, including during clear.
- Simultaneous presses in one cycle: only the highest-priority one is considered, order up > right > down > left; the others are discarded silently.
- Reference heading: tail (newest) FIFO entry if count>0, else dir. Uses pre-edge register values.
- Reject silently if press == ref or press == ref ^ 2 (reversal). Direction arithmetic is 2-bit, wraps mod 4.
- Otherwise, if count == DEPTH (pre-edge value, even with a pop in the same cycle), reject and pulse dropped. Else push.
- Pop: on tick with count>0, dir <= head entry, pop, turned <= 1. tick with count==0: dir unchanged, turned stays 0.
- Push and pop in the same cycle: both happen, count unchanged. With count==1, ref = the entry being popped, which is consistent with the new dir.
- clear has priority over push/pop. It empties the FIFO (count=0, pointers 0), sets dir=RIGHT, and forces turned=0 and dropped=0. A press in the clear cycle is discarded.
- Reset values: dir=RIGHT(1), count=0, turned=0, dropped=0, pointers 0, all prev=0. Reset assertion mid-operation discards queued turns immediately (asynchronous).

## Timing
- Press accepted on edge k (btn high, prev low) -> count increments at edge k.
- tick sampled at edge j ≥ k+1 -> dir valid after edge j; turned high for cycle j..j+1 only.
- Press and tick on the same edge with empty FIFO: the tick finds nothing. The new entry waits for the next tick.
- Holding a button produces exactly one press. Release and re-press yields another.
- dropped is high for exactly the one cycle after the rejecting edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package/header snake_pkg: direction encodings (DIR_UP..DIR_LEFT), DIR_RESET=RIGHT, opposite = d ^ 2. Also used by movement and collision logic.
- Sub-module dir_fifo: synchronous FIFO, 2-bit data, DEPTH entries. Ports: push, pop, clear, head, tail, count. Registered pointers with wrap at DEPTH.
- Top: edge detect, priority select, validation, dir/turned/dropped registers.

## Test plan
- Reset then idle -> dir=1, count=0, turned=0. Hold btn_up 100 cycles -> count=1 exactly once. tick -> dir=0, turned pulses 1 cycle.
- dir=RIGHT, press left -> rejected, count stays 0. Press right -> rejected. Press down then left, then 2 ticks -> dir=2 then 3.
- DEPTH=2: press up, left, down (each valid vs tail) -> count=2, third press dropped=1 for one cycle, FIFO contents unchanged.
- count=1 (UP), press left on the same edge as tick -> dir=0, count=1, head=LEFT.
- btn_up and btn_left rise on the same edge from dir=RIGHT -> only UP queued. clear with count=2 -> count=0, dir=1. Async reset mid-queue -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encodings and helpers used by
// the turn queue, movement and collision logic.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  // Flipping bit 1 gives the 180-degree reversal in this encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of pending turns; exposes both head (next to pop)
// and tail (newest) so the caller can validate against the latest request.
module dir_fifo
  import snake_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  dir_t          din,
  output dir_t          head,
  output dir_t          tail,
  output logic [CW-1:0] count
);

  dir_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_wptr_nxt;
  logic [AW-1:0]   w_rptr_nxt;
  logic [AW-1:0]   w_tail_idx;

  always_comb begin
    w_push     = push && (r_count != CW'(DEPTH));
    w_pop      = pop && (r_count != '0);
    w_wptr_nxt = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    w_rptr_nxt = (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    w_tail_idx = (r_wptr == '0) ? AW'(DEPTH - 1) : r_wptr - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DIR_RESET;
      end
    end else if (w_push && !clear) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rptr];
  assign tail  = r_mem[w_tail_idx];
  assign count = r_count;

endmodule

// File: rtl/snake_dir_queue.sv
// Turn-command stage: edge-detects debounced direction buttons, rejects
// no-op and reversal requests, and queues valid turns for the game tick.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_up,
  input  logic          btn_right,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          tick,
  input  logic          clear,
  output logic [1:0]    dir,
  output logic          turned,
  output logic [CW-1:0] count,
  output logic          dropped
);

  logic [3:0]    r_prev;
  dir_t          r_dir;
  logic          r_turned;
  logic          r_dropped;

  logic [3:0]    w_btn;
  logic [3:0]    w_press;
  dir_t          w_sel;
  dir_t          w_ref;
  dir_t          w_head;
  dir_t          w_tail;
  logic [CW-1:0] w_count;
  logic          w_legal;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  always_comb begin
    w_btn   = {btn_left, btn_down, btn_right, btn_up};
    w_press = w_btn & ~r_prev;

    w_sel = DIR_UP;
    if      (w_press[0]) w_sel = DIR_UP;
    else if (w_press[1]) w_sel = DIR_RIGHT;
    else if (w_press[2]) w_sel = DIR_DOWN;
    else if (w_press[3]) w_sel = DIR_LEFT;

    // Validate against the newest queued turn so chained taps are judged
    // relative to where the snake will be heading, not where it is now.
    w_ref   = (w_count != '0) ? w_tail : r_dir;
    w_legal = (w_press != '0) && (w_sel != w_ref) && (w_sel != opposite(w_ref));
    w_full  = (w_count == CW'(DEPTH));

    w_push = w_legal && !w_full && !clear;
    w_drop = w_legal &&  w_full && !clear;
    w_pop  = tick && (w_count != '0) && !clear;
  end

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .clear (clear),
    .din   (w_sel),
    .head  (w_head),
    .tail  (w_tail),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_dir     <= DIR_RESET;
      r_turned  <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_prev <= w_btn;
      if (clear) begin
        r_dir     <= DIR_RESET;
        r_turned  <= 1'b0;
        r_dropped <= 1'b0;
      end else begin
        r_turned  <= w_pop;
        r_dropped <= w_drop;
        if (w_pop) r_dir <= w_head;
      end
    end
  end

  assign dir     = r_dir;
  assign turned  = r_turned;
  assign count   = w_count;
  assign dropped = r_dropped;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Bench for snake_dir_queue: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_snake_dir_queue;

  localparam int DEPTH = 2;

  logic       clk;
  logic       reset;
  logic       btn_up, btn_right, btn_down, btn_left;
  logic       tick, clear;
  logic [1:0] dir;
  logic       turned;
  logic [1:0] count;
  logic       dropped;

  int n_checks = 0;
  int n_err    = 0;

  snake_dir_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .tick      (tick),
    .clear     (clear),
    .dir       (dir),
    .turned    (turned),
    .count     (count),
    .dropped   (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a plain queue of headings, button index == direction code.
  int       mq[$];
  int       m_dir;
  bit [3:0] m_prev;
  int       m_turn;
  int       m_drop;

  task automatic model_reset();
    mq.delete();
    m_dir  = 1;
    m_prev = '0;
    m_turn = 0;
    m_drop = 0;
  endtask

  task automatic model_step(input logic [3:0] b, input logic tk, input logic cl);
    int  p;
    int  sz;
    int  refd;
    bit  dopush;
    p = -1;
    for (int i = 0; i < 4; i++) begin
      if (p < 0 && b[i] && !m_prev[i]) p = i;
    end
    m_prev = b;
    m_turn = 0;
    m_drop = 0;
    if (cl) begin
      mq.delete();
      m_dir = 1;
      return;
    end
    sz     = mq.size();
    refd   = (sz > 0) ? mq[sz-1] : m_dir;
    dopush = 0;
    if (p >= 0 && p != refd && p != (refd + 2) % 4) begin
      if (sz == DEPTH) m_drop = 1;
      else             dopush = 1;
    end
    if (tk && sz > 0) begin
      m_dir  = mq.pop_front();
      m_turn = 1;
    end
    if (dopush) mq.push_back(p);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic tk, input logic cl);
    {btn_left, btn_down, btn_right, btn_up} = b;
    tick  = tk;
    clear = cl;
    @(posedge clk);
    #1;
    model_step(b, tk, cl);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dir"},     int'(dir),     m_dir);
    chk({tag, "_count"},   int'(count),   mq.size());
    chk({tag, "_turned"},  int'(turned),  m_turn);
    chk({tag, "_dropped"}, int'(dropped), m_drop);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    {btn_left, btn_down, btn_right, btn_up} = '0;
    tick  = 1'b0;
    clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk({tag, "_dir"},     int'(dir),     1);
    chk({tag, "_count"},   int'(count),   0);
    chk({tag, "_turned"},  int'(turned),  0);
    chk({tag, "_dropped"}, int'(dropped), 0);
    #2 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] btn;     // {left, down, right, up}
    logic       tk;
    logic       cl;
    logic [1:0] e_dir;
    logic [1:0] e_cnt;
    logic       e_turn;
    logic       e_drop;
  } vec_t;

  vec_t vq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rb;
    logic       rt, rc;
    int         idx;

    reset = 1'b1;
    {btn_left, btn_down, btn_right, btn_up} = '0;
    tick  = 1'b0;
    clear = 1'b0;
    model_reset();
    #12 reset = 1'b0;
    chk("reset_dir",     int'(dir),     1);
    chk("reset_count",   int'(count),   0);
    chk("reset_turned",  int'(turned),  0);
    chk("reset_dropped", int'(dropped), 0);

    //               btn      tk    cl    dir   cnt   turn  drop
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0}); // idle
    vq.push_back('{4'b0001, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0}); // up queued
    vq.push_back('{4'b0001, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0}); // held
    vq.push_back('{4'b0001, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0});
    vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}); // pop up
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}); // turned 1 cycle
    vq.push_back('{4'b0100, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}); // reversal
    vq.push_back('{4'b0001, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0}); // no-op
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0});
    vq.push_back('{4'b0010, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0}); // right
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0});
    vq.push_back('{4'b1000, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0}); // left vs tail right
    vq.push_back('{4'b0100, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0}); // down, full
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0});
    vq.push_back('{4'b1000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1}); // dropped
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0}); // one-cycle pulse
    vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0}); // pop right
    vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0}); // pop down
    vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0}); // empty tick
    vq.push_back('{4'b1010, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0}); // right beats left
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0});
    vq.push_back('{4'b0100, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0}); // push+pop
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0});
    vq.push_back('{4'b0001, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0}); // clear wins
    vq.push_back('{4'b0001, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0}); // still held
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0});
    vq.push_back('{4'b0001, 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0}); // tick finds empty
    vq.push_back('{4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0}); // now popped
    vq.push_back('{4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].btn, vq[i].tk, vq[i].cl);
      chk($sformatf("vec%0d_dir", i),     int'(dir),     int'(vq[i].e_dir));
      chk($sformatf("vec%0d_count", i),   int'(count),   int'(vq[i].e_cnt));
      chk($sformatf("vec%0d_turned", i),  int'(turned),  int'(vq[i].e_turn));
      chk($sformatf("vec%0d_dropped", i), int'(dropped), int'(vq[i].e_drop));
    end

    // Queue a turn, then hit asynchronous reset mid-queue.
    step(4'b0010, 1'b0, 1'b0);
    chk("preq_count", int'(count), 1);
    async_reset("areset");

    // Holding up for 100 cycles queues exactly one turn.
    for (int i = 0; i < 100; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      chk("hold_count", int'(count), 1);
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("hold_tick_dir",    int'(dir),    0);
    chk("hold_tick_turned", int'(turned), 1);
    step(4'b0000, 1'b0, 1'b0);
    chk("hold_after_turned", int'(turned), 0);
    check_model("hold_model");

    // Randomized traffic against the reference model.
    rb = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, 3));
        rb[idx] = ~rb[idx];
      end
      rt = ($urandom_range(0, 4) == 0);
      rc = ($urandom_range(0, 79) == 0);
      step(rb, rt, rc);
      check_model("rand");
      if ($urandom_range(0, 599) == 0) begin
        async_reset("rand_areset");
        rb = '0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
